dct_transpose: RTL and testbench

- Ping-pong 8x8 transpose buffer sitting directly downstream of dct_1d.
- Accepts 12-bit signed 1-D DCT coefficients in row-major order (S_in = dct_1d S_out, ena_in = dct_1d output-valid).
- Re-emits each 8x8 block in column-major order so a second dct_1d pass can compute the 2-D DCT.
- Two banks let block N+1 be written while block N is read, with no stall at full rate of one sample per clock.

---
 rtl/dct_transpose.sv | 129 ++++++++++++
 tb/tb_dct_transpose.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose.sv
// dct_transpose: ping-pong N x N transpose buffer placed after dct_1d.
// Samples arrive in row-major order and are re-emitted in column-major order.
// Two banks let one block be written while the other is read. The buffer
// runs at one sample per clock without stalling.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ena_in     S_in is valid this cycle and is written on this edge
//   S_in       signed coefficient, row-major within a block
//   ena_out    d_out is valid this cycle
//   d_out      signed coefficient, column-major within a block
//   blk_first  marks output element [0][0]
//   blk_last   marks output element [N-1][N-1]
//
// Read FSM states:
//   state | meaning
//   IDLE  | no full bank waiting; outputs idle
//   READ  | draining bank r_rd_bank, one sample per clock
module dct_transpose #(
  parameter int N     = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_in,
  input  logic [WIDTH-1:0] S_in,
  output logic             ena_out,
  output logic [WIDTH-1:0] d_out,
  output logic             blk_first,
  output logic             blk_last
);

  localparam int LOG_N = $clog2(N);
  localparam int AW    = 2 * LOG_N;
  localparam int DEPTH = N * N;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mem [0:2*DEPTH-1];
  logic             r_wr_bank, r_rd_bank;
  logic [AW-1:0]    r_wr_cnt, r_rd_cnt;
  logic [1:0]       r_full, w_full_nxt;
  logic             w_wr_done, w_rd_done;
  logic [AW:0]      w_rd_addr;

  assign w_wr_done = ena_in && (r_wr_cnt == LAST_IDX);
  assign w_rd_done = (r_state == READ) && (r_rd_cnt == LAST_IDX);
  // The write index is row*N+col. Reading element [rd%N][rd/N] swaps the two
  // halves of the counter, which gives the transpose (N is a power of two).
  assign w_rd_addr = {r_rd_bank, r_rd_cnt[LOG_N-1:0], r_rd_cnt[AW-1:LOG_N]};

  // Bank RAM has no reset; stale contents are never read without a full write.
  always_ff @(posedge clk) begin
    if (ena_in) begin
      r_mem[{r_wr_bank, r_wr_cnt}] <= S_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (ena_in) begin
      r_wr_cnt <= w_wr_done ? '0 : r_wr_cnt + 1'b1;
      if (w_wr_done) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // The writer sets one bank and the reader clears the other. Both can happen
  // on the same edge without interacting.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_done) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
    if (w_wr_done) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (r_full[r_rd_bank]) w_state_nxt = READ;
      READ: if (w_rd_done) w_state_nxt = r_full[~r_rd_bank] ? READ : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_full    <= 2'b00;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= w_full_nxt;
      if (r_state == READ) begin
        r_rd_cnt <= w_rd_done ? '0 : r_rd_cnt + 1'b1;
        if (w_rd_done) begin
          r_rd_bank <= ~r_rd_bank;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ena_out   <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
      d_out     <= '0;
    end else begin
      ena_out   <= (r_state == READ);
      blk_first <= (r_state == READ) && (r_rd_cnt == '0);
      blk_last  <= w_rd_done;
      if (r_state == READ) begin
        d_out <= r_mem[w_rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
module tb_dct_transpose;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena_in;
  logic [11:0] S_in;
  logic        ena_out;
  logic [11:0] d_out;
  logic        blk_first;
  logic        blk_last;

  dct_transpose #(.N(8), .WIDTH(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena_in    (ena_in),
    .S_in      (S_in),
    .ena_out   (ena_out),
    .d_out     (d_out),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: collect a block as a row/col matrix and, once complete,
  // schedule its 64 outputs column by column. A block starts 2 edges after its
  // last sample, or right after the previous block if that one is still out.
  typedef struct {
    int          cyc;
    logic [11:0] val;
    logic        first;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [11:0] blk [8][8];
  int          wr_n = 0;
  int          cyc = 0;
  int          last_end = 0;

  always @(posedge clk) begin
    int start;
    cyc++;
    if (rst) begin
      q.delete();
      wr_n = 0;
      last_end = 0;
    end else if (ena_in) begin
      blk[wr_n / 8][wr_n % 8] = S_in;
      wr_n++;
      if (wr_n == 64) begin
        start = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
        for (int c = 0; c < 8; c++) begin
          for (int r = 0; r < 8; r++) begin
            exp_t e;
            e.cyc   = start + c * 8 + r;
            e.val   = blk[r][c];
            e.first = (r == 0 && c == 0);
            e.last  = (r == 7 && c == 7);
            q.push_back(e);
          end
        end
        last_end = start + 63;
        wr_n = 0;
      end
    end
  end

  bit mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("ena_out_hi", {31'b0, ena_out}, 32'd1);
        chk("d_out", {20'b0, d_out}, {20'b0, e.val});
        chk("blk_first", {31'b0, blk_first}, {31'b0, e.first});
        chk("blk_last", {31'b0, blk_last}, {31'b0, e.last});
      end else begin
        chk("ena_out_lo", {31'b0, ena_out}, 32'd0);
      end
    end
  end

  task automatic drive(input logic en, input logic [11:0] v);
    ena_in = en;
    S_in   = v;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    ena_in = 1'b0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    ena_in = 1'b0;
    S_in   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ena_out", {31'b0, ena_out}, 32'd0);
    chk("rst_blk_first", {31'b0, blk_first}, 32'd0);
    chk("rst_blk_last", {31'b0, blk_last}, 32'd0);
    chk("rst_d_out", {20'b0, d_out}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Ramp block.
    for (int i = 0; i < 64; i++) drive(1'b1, 12'(16 * (i / 8) + (i % 8)));
    drain();

    // Three back-to-back blocks.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++) drive(1'b1, 12'(100 * k + i));
    drain();

    // Gapped ramp; junk on S_in during the gaps.
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 12'(16 * (i / 8) + (i % 8)));
      drive(1'b0, 12'($urandom));
    end
    drain();

    // Extremes.
    for (int i = 0; i < 64; i++) drive(1'b1, (i % 2 == 1) ? 12'h7FF : 12'h800);
    drain();

    // Random blocks with random gaps.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++) begin
        drive(1'b1, 12'($urandom));
        repeat ($urandom_range(0, 2)) drive(1'b0, 12'($urandom));
      end
    drain();

    // Reset in the middle of a read.
    for (int i = 0; i < 64; i++) drive(1'b1, 12'($urandom));
    ena_in = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain();

    // Reset after 40 samples of a block, then a full ramp.
    for (int i = 0; i < 40; i++) drive(1'b1, 12'($urandom));
    ena_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) drive(1'b1, 12'(16 * (i / 8) + (i % 8)));
    drain();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
